// File: rtl/l2_tag_ctrl_pkg.sv
// Shared types and widths for the L2 tag sequencer: state encodings,
// request source codes and the tag/index/address field widths.
package l2_tag_ctrl_pkg;

  localparam int L2_INDEX_W = 9;
  localparam int L2_TAG_W   = 18;
  localparam int L2_ADDR_W  = 26;

  typedef enum logic [2:0] {
    L2_IDLE    = 3'd0,
    L2_LOOKUP  = 3'd1,
    L2_COMPARE = 3'd2,
    L2_WB      = 3'd3,
    L2_FILL    = 3'd4,
    L2_UPDATE  = 3'd5
  } l2_state_e;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } l2_src_e;

endpackage

// File: rtl/l2_tag_ctrl_if.sv
// L1 request/response and memory writeback/fill handshakes of the L2 tag
// sequencer. The controller uses the slave modport.
interface l2_tag_ctrl_if;
  import l2_tag_ctrl_pkg::*;

  logic                 ic_req;
  logic [L2_ADDR_W-1:0] ic_addr;
  logic                 ic_ack;
  logic                 dc_req;
  logic [L2_ADDR_W-1:0] dc_addr;
  logic                 dc_wr;
  logic                 dc_ack;
  logic                 resp_hit;
  logic [1:0]           resp_way;
  logic                 wb_req;
  logic [L2_ADDR_W-1:0] wb_addr;
  logic                 wb_ack;
  logic                 mem_req;
  logic [L2_ADDR_W-1:0] mem_addr;
  logic                 mem_ack;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_addr, dc_wr, wb_ack, mem_ack,
    output ic_ack, dc_ack, resp_hit, resp_way, wb_req, wb_addr, mem_req, mem_addr
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_addr, dc_wr, wb_ack, mem_ack,
    input  ic_ack, dc_ack, resp_hit, resp_way, wb_req, wb_addr, mem_req, mem_addr
  );

endinterface

// File: rtl/l2_tag_ctrl_victim_sel.sv
// Victim way decode for a 4-way set: lowest invalid way first, otherwise
// the tree-PLRU choice.
module l2_victim_sel (
  input  logic [3:0] valid,
  input  logic [2:0] plru,
  output logic [1:0] victim
);

  // plru[0] picks the half, plru[1]/plru[2] pick the way inside that half.
  always_comb begin
    victim = 2'd0;
    if (!valid[0])      victim = 2'd0;
    else if (!valid[1]) victim = 2'd1;
    else if (!valid[2]) victim = 2'd2;
    else if (!valid[3]) victim = 2'd3;
    else if (!plru[0])  victim = plru[1] ? 2'd1 : 2'd0;
    else                victim = plru[2] ? 2'd3 : 2'd2;
  end

endmodule

// File: rtl/l2_tag_ctrl.sv
// Round-robin IC/DC arbiter and lookup/writeback/fill/update sequencer for the
// 4-way L2 tag array. Optional counters enabled by L2_TAG_CTRL_STAT_EN.
module l2_tag_ctrl
  import l2_tag_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  l2_tag_ctrl_if.slave          bus,
  output logic [L2_INDEX_W-1:0] l2_index,
  output logic [3:0]            l2_block_we,
  output logic [L2_TAG_W-1:0]   l2_tag_wd,
  output logic                  l2_dirty_wd,
  input  logic [L2_TAG_W-1:0]   l2_tag0_rd,
  input  logic [L2_TAG_W-1:0]   l2_tag1_rd,
  input  logic [L2_TAG_W-1:0]   l2_tag2_rd,
  input  logic [L2_TAG_W-1:0]   l2_tag3_rd,
  input  logic                  l2_dirty0,
  input  logic                  l2_dirty1,
  input  logic                  l2_dirty2,
  input  logic                  l2_dirty3,
  input  logic [2:0]            plru
`ifdef L2_TAG_CTRL_STAT_EN
  ,
  output logic [31:0]           stat_hit,
  output logic [31:0]           stat_miss,
  output logic [31:0]           stat_wb
`endif
);

  l2_state_e               state_q, state_d;
  l2_src_e                 src_q, src_d;
  l2_src_e                 last_grant_q, last_grant_d;
  logic                    wr_q, wr_d;
  logic [L2_ADDR_W-1:0]    addr_q, addr_d;
  logic [L2_INDEX_W-1:0]   index_q, index_d;
  logic [1:0]              way_q, way_d;
  logic                    hit_q, hit_d;
  logic                    old_dirty_q, old_dirty_d;
  logic [L2_TAG_W-2:0]     victim_tag_q, victim_tag_d;

  logic [L2_TAG_W-1:0]     tag_rd [4];
  logic [3:0]              dirty_rd;
  logic [3:0]              valid;
  logic [3:0]              match;
  logic [L2_TAG_W-2:0]     req_tag;
  logic                    hit;
  logic [1:0]              hit_way;
  logic [1:0]              victim;
  logic                    victim_dirty;
  logic                    grant_ic;
  logic                    grant_dc;
  logic                    dc_store;

  assign tag_rd[0] = l2_tag0_rd;
  assign tag_rd[1] = l2_tag1_rd;
  assign tag_rd[2] = l2_tag2_rd;
  assign tag_rd[3] = l2_tag3_rd;
  assign dirty_rd  = {l2_dirty3, l2_dirty2, l2_dirty1, l2_dirty0};
  assign req_tag   = addr_q[L2_ADDR_W-1:L2_INDEX_W];
  assign l2_index  = index_q;
  assign dc_store  = (src_q == SRC_DC) && wr_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      valid[i] = tag_rd[i][L2_TAG_W-1];
      match[i] = valid[i] && (tag_rd[i][L2_TAG_W-2:0] == req_tag);
    end
  end

  // Scanning downwards leaves the lowest matching way if the set is corrupt.
  always_comb begin
    hit     = 1'b0;
    hit_way = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_way = 2'(i);
      end
    end
  end

  l2_victim_sel u_victim_sel (
    .valid  (valid),
    .plru   (plru),
    .victim (victim)
  );

  assign victim_dirty = valid[victim] && dirty_rd[victim];

  // A tie goes to whichever source was not granted last.
  assign grant_ic = bus.ic_req && (!bus.dc_req || (last_grant_q == SRC_DC));
  assign grant_dc = bus.dc_req && (!bus.ic_req || (last_grant_q == SRC_IC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= L2_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      L2_IDLE:    if (grant_ic || grant_dc) state_d = L2_LOOKUP;
      L2_LOOKUP:  state_d = L2_COMPARE;
      L2_COMPARE: begin
        if (hit)               state_d = L2_UPDATE;
        else if (victim_dirty) state_d = L2_WB;
        else                   state_d = L2_FILL;
      end
      L2_WB:      if (bus.wb_ack)  state_d = L2_FILL;
      L2_FILL:    if (bus.mem_ack) state_d = L2_UPDATE;
      L2_UPDATE:  state_d = L2_IDLE;
      default:    state_d = L2_IDLE;
    endcase
  end

  always_comb begin
    src_d        = src_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    index_d      = index_q;
    way_d        = way_q;
    hit_d        = hit_q;
    old_dirty_d  = old_dirty_q;
    victim_tag_d = victim_tag_q;
    case (state_q)
      L2_IDLE: begin
        if (grant_ic) begin
          src_d        = SRC_IC;
          last_grant_d = SRC_IC;
          wr_d         = 1'b0;
          addr_d       = bus.ic_addr;
          index_d      = bus.ic_addr[L2_INDEX_W-1:0];
        end else if (grant_dc) begin
          src_d        = SRC_DC;
          last_grant_d = SRC_DC;
          wr_d         = bus.dc_wr;
          addr_d       = bus.dc_addr;
          index_d      = bus.dc_addr[L2_INDEX_W-1:0];
        end
      end
      L2_COMPARE: begin
        hit_d        = hit;
        way_d        = hit ? hit_way : victim;
        old_dirty_d  = dirty_rd[hit_way];
        victim_tag_d = tag_rd[victim][L2_TAG_W-2:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q        <= SRC_IC;
      last_grant_q <= SRC_DC;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      index_q      <= '0;
      way_q        <= 2'd0;
      hit_q        <= 1'b0;
      old_dirty_q  <= 1'b0;
      victim_tag_q <= '0;
    end else begin
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      index_q      <= index_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      old_dirty_q  <= old_dirty_d;
      victim_tag_q <= victim_tag_d;
    end
  end

  // Handshake and write strobes decode purely from state, so reset drops them at once.
  always_comb begin
    bus.ic_ack   = 1'b0;
    bus.dc_ack   = 1'b0;
    bus.resp_hit = 1'b0;
    bus.resp_way = 2'd0;
    bus.wb_req   = 1'b0;
    bus.wb_addr  = '0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    l2_block_we  = 4'b0000;
    l2_tag_wd    = '0;
    l2_dirty_wd  = 1'b0;
    case (state_q)
      L2_WB: begin
        bus.wb_req  = 1'b1;
        bus.wb_addr = {victim_tag_q, index_q};
      end
      L2_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
      end
      L2_UPDATE: begin
        bus.ic_ack   = (src_q == SRC_IC);
        bus.dc_ack   = (src_q == SRC_DC);
        bus.resp_hit = hit_q;
        bus.resp_way = way_q;
        l2_block_we  = 4'b0001 << way_q;
        l2_tag_wd    = {1'b1, req_tag};
        l2_dirty_wd  = hit_q ? (old_dirty_q || dc_store) : dc_store;
      end
      default: ;
    endcase
  end

`ifdef L2_TAG_CTRL_STAT_EN
  logic [31:0] stat_hit_q, stat_hit_d;
  logic [31:0] stat_miss_q, stat_miss_d;
  logic [31:0] stat_wb_q, stat_wb_d;

  always_comb begin
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
    stat_wb_d   = stat_wb_q;
    if (state_q == L2_COMPARE) begin
      if (hit) stat_hit_d  = stat_hit_q + 32'd1;
      else     stat_miss_d = stat_miss_q + 32'd1;
    end
    if ((state_q == L2_WB) && bus.wb_ack) stat_wb_d = stat_wb_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
      stat_wb_q   <= '0;
    end else begin
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
      stat_wb_q   <= stat_wb_d;
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
  assign stat_wb   = stat_wb_q;
`endif

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Directed bench for l2_tag_ctrl: a behavioural tag/dirty RAM model, a vector
// table of full transactions, and hand sequences for arbitration and reset.
module tb_l2_tag_ctrl;
  import l2_tag_ctrl_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [L2_INDEX_W-1:0] l2_index;
  logic [3:0]            l2_block_we;
  logic [L2_TAG_W-1:0]   l2_tag_wd;
  logic                  l2_dirty_wd;
  logic [L2_TAG_W-1:0]   tag_rd [4];
  logic [3:0]            dirty_rd;
  logic [2:0]            plru;
`ifdef L2_TAG_CTRL_STAT_EN
  logic [31:0]           stat_hit, stat_miss, stat_wb;
`endif

  l2_tag_ctrl_if bus ();

  l2_tag_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .l2_index    (l2_index),
    .l2_block_we (l2_block_we),
    .l2_tag_wd   (l2_tag_wd),
    .l2_dirty_wd (l2_dirty_wd),
    .l2_tag0_rd  (tag_rd[0]),
    .l2_tag1_rd  (tag_rd[1]),
    .l2_tag2_rd  (tag_rd[2]),
    .l2_tag3_rd  (tag_rd[3]),
    .l2_dirty0   (dirty_rd[0]),
    .l2_dirty1   (dirty_rd[1]),
    .l2_dirty2   (dirty_rd[2]),
    .l2_dirty3   (dirty_rd[3]),
    .plru        (plru)
`ifdef L2_TAG_CTRL_STAT_EN
    ,
    .stat_hit    (stat_hit),
    .stat_miss   (stat_miss),
    .stat_wb     (stat_wb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tag RAM model: synchronous read one cycle after index, write on way strobe.
  logic [L2_TAG_W-1:0]   tag_mem   [512][4];
  logic                  dirty_mem [512][4];
  logic                  mem_clear;
  logic                  poke_en;
  logic [L2_INDEX_W-1:0] poke_set;
  logic [1:0]            poke_way;
  logic [L2_TAG_W-1:0]   poke_tag;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int s = 0; s < 512; s++)
        for (int w = 0; w < 4; w++) begin
          tag_mem[s][w]   <= '0;
          dirty_mem[s][w] <= 1'b0;
        end
    end else if (poke_en) begin
      tag_mem[poke_set][poke_way]   <= poke_tag;
      dirty_mem[poke_set][poke_way] <= 1'b0;
    end else begin
      for (int w = 0; w < 4; w++)
        if (l2_block_we[w]) begin
          tag_mem[l2_index][w]   <= l2_tag_wd;
          dirty_mem[l2_index][w] <= l2_dirty_wd;
        end
    end
    for (int w = 0; w < 4; w++) begin
      tag_rd[w]   <= tag_mem[l2_index][w];
      dirty_rd[w] <= dirty_mem[l2_index][w];
    end
  end

  typedef struct {
    logic                 dc;
    logic                 wr;
    logic [L2_ADDR_W-1:0] addr;
    logic [2:0]           plru;
    logic                 hit;
    logic [1:0]           way;
    logic                 wb;
    logic [L2_ADDR_W-1:0] wb_addr;
    logic [L2_TAG_W-1:0]  tag_wd;
    logic                 dirty_wd;
    logic [3:0]           we;
    int                   lat;
  } vec_t;

  vec_t vecs [13];
  int   tests;
  int   fails;

  logic                 obs_done, obs_dc, obs_hit, obs_wb, obs_mem, obs_dirty;
  logic [1:0]           obs_way;
  logic [3:0]           obs_we;
  logic [L2_TAG_W-1:0]  obs_tag;
  logic [L2_ADDR_W-1:0] obs_wb_addr, obs_mem_addr;
  int                   obs_lat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one request to completion, answering wb/mem handshakes immediately.
  task automatic applyStimulus(input logic dc, input logic wr, input logic [L2_ADDR_W-1:0] addr);
    @(negedge clk);
    if (dc) begin
      bus.dc_req  = 1'b1;
      bus.dc_addr = addr;
      bus.dc_wr   = wr;
    end else begin
      bus.ic_req  = 1'b1;
      bus.ic_addr = addr;
    end
    obs_done = 0; obs_dc = 0; obs_hit = 0; obs_wb = 0; obs_mem = 0; obs_dirty = 0;
    obs_way = 0; obs_we = 0; obs_tag = 0; obs_wb_addr = 0; obs_mem_addr = 0; obs_lat = 0;
    for (int c = 1; c <= 40 && !obs_done; c++) begin
      @(negedge clk);
      bus.wb_ack  = bus.wb_req;
      bus.mem_ack = bus.mem_req;
      if (bus.wb_req) begin
        obs_wb      = 1'b1;
        obs_wb_addr = bus.wb_addr;
      end
      if (bus.mem_req) begin
        obs_mem      = 1'b1;
        obs_mem_addr = bus.mem_addr;
      end
      if (bus.ic_ack || bus.dc_ack) begin
        obs_done  = 1'b1;
        obs_lat   = c;
        obs_dc    = bus.dc_ack;
        obs_hit   = bus.resp_hit;
        obs_way   = bus.resp_way;
        obs_we    = l2_block_we;
        obs_tag   = l2_tag_wd;
        obs_dirty = l2_dirty_wd;
        bus.ic_req = 1'b0;
        bus.dc_req = 1'b0;
        bus.dc_wr  = 1'b0;
      end
    end
    bus.ic_req  = 1'b0;
    bus.dc_req  = 1'b0;
    bus.wb_ack  = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  logic       ack_src [4];
  logic       ack_hit [4];
  int         ack_cnt;
  logic       saw_mem;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    plru  = 3'b000;
    bus.ic_req = 0; bus.ic_addr = 0; bus.dc_req = 0; bus.dc_addr = 0; bus.dc_wr = 0;
    bus.wb_ack = 0; bus.mem_ack = 0;
    mem_clear = 1'b1; poke_en = 1'b0; poke_set = 0; poke_way = 0; poke_tag = 0;

    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    checkOutput("rst_ic_ack",  32'(bus.ic_ack), 0);
    checkOutput("rst_dc_ack",  32'(bus.dc_ack), 0);
    checkOutput("rst_wb_req",  32'(bus.wb_req), 0);
    checkOutput("rst_mem_req", 32'(bus.mem_req), 0);
    checkOutput("rst_we",      32'(l2_block_we), 0);
    checkOutput("rst_index",   32'(l2_index), 0);
    checkOutput("rst_tag_wd",  32'(l2_tag_wd), 0);
    rst_n = 1'b1;

    // Both requesters held from reset: IC first, then strict alternation.
    @(negedge clk);
    bus.ic_req = 1'b1; bus.ic_addr = 26'h0000100;
    bus.dc_req = 1'b1; bus.dc_addr = 26'h0000300; bus.dc_wr = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 80 && ack_cnt < 4; c++) begin
      @(negedge clk);
      bus.wb_ack  = bus.wb_req;
      bus.mem_ack = bus.mem_req;
      if (bus.ic_ack || bus.dc_ack) begin
        ack_src[ack_cnt] = bus.dc_ack;
        ack_hit[ack_cnt] = bus.resp_hit;
        ack_cnt++;
        if (ack_cnt == 4) begin
          bus.ic_req = 1'b0;
          bus.dc_req = 1'b0;
        end
      end
    end
    bus.ic_req = 1'b0; bus.dc_req = 1'b0; bus.wb_ack = 1'b0; bus.mem_ack = 1'b0;
    checkOutput("arb_ack_count", 32'(ack_cnt), 4);
    if (ack_cnt == 4) begin
      checkOutput("arb_src0", 32'(ack_src[0]), 0);
      checkOutput("arb_src1", 32'(ack_src[1]), 1);
      checkOutput("arb_src2", 32'(ack_src[2]), 0);
      checkOutput("arb_src3", 32'(ack_src[3]), 1);
      checkOutput("arb_hit0", 32'(ack_hit[0]), 0);
      checkOutput("arb_hit2", 32'(ack_hit[2]), 1);
      checkOutput("arb_hit3", 32'(ack_hit[3]), 1);
    end

    // Corrupt set 0x005 with the same valid tag in ways 1 and 3.
    @(negedge clk);
    poke_en = 1'b1; poke_set = 9'h005; poke_way = 2'd1; poke_tag = 18'h20055;
    @(negedge clk);
    poke_way = 2'd3;
    @(negedge clk);
    poke_en = 1'b0;

    //            dc wr addr        plru    hit way wb wb_addr      tag_wd     dw we       lat
    vecs[0]  = '{1'b0, 1'b0, 26'h0001234, 3'b000, 1'b0, 2'd0, 1'b0, 26'h0,       18'h20009, 1'b0, 4'b0001, 4};
    vecs[1]  = '{1'b0, 1'b0, 26'h0001234, 3'b000, 1'b1, 2'd0, 1'b0, 26'h0,       18'h20009, 1'b0, 4'b0001, 3};
    vecs[2]  = '{1'b1, 1'b1, 26'h0001234, 3'b000, 1'b1, 2'd0, 1'b0, 26'h0,       18'h20009, 1'b1, 4'b0001, 3};
    vecs[3]  = '{1'b1, 1'b1, 26'h0000434, 3'b000, 1'b0, 2'd1, 1'b0, 26'h0,       18'h20002, 1'b1, 4'b0010, 4};
    vecs[4]  = '{1'b1, 1'b1, 26'h0000634, 3'b000, 1'b0, 2'd2, 1'b0, 26'h0,       18'h20003, 1'b1, 4'b0100, 4};
    vecs[5]  = '{1'b0, 1'b0, 26'h0000834, 3'b000, 1'b0, 2'd3, 1'b0, 26'h0,       18'h20004, 1'b0, 4'b1000, 4};
    vecs[6]  = '{1'b0, 1'b0, 26'h0000A34, 3'b011, 1'b0, 2'd2, 1'b1, 26'h0000634, 18'h20005, 1'b0, 4'b0100, 5};
    vecs[7]  = '{1'b0, 1'b0, 26'h0000434, 3'b000, 1'b1, 2'd1, 1'b0, 26'h0,       18'h20002, 1'b1, 4'b0010, 3};
    vecs[8]  = '{1'b0, 1'b0, 26'h0000C34, 3'b010, 1'b0, 2'd1, 1'b1, 26'h0000434, 18'h20006, 1'b0, 4'b0010, 5};
    vecs[9]  = '{1'b0, 1'b0, 26'h0000E34, 3'b100, 1'b0, 2'd0, 1'b1, 26'h0001234, 18'h20007, 1'b0, 4'b0001, 5};
    vecs[10] = '{1'b0, 1'b0, 26'h0001034, 3'b101, 1'b0, 2'd3, 1'b0, 26'h0,       18'h20008, 1'b0, 4'b1000, 4};
    vecs[11] = '{1'b1, 1'b0, 26'h0000001, 3'b000, 1'b0, 2'd0, 1'b0, 26'h0,       18'h20000, 1'b0, 4'b0001, 4};
    vecs[12] = '{1'b0, 1'b0, 26'h000AA05, 3'b000, 1'b1, 2'd1, 1'b0, 26'h0,       18'h20055, 1'b0, 4'b0010, 3};

    for (int i = 0; i < 13; i++) begin
      plru = vecs[i].plru;
      applyStimulus(vecs[i].dc, vecs[i].wr, vecs[i].addr);
      checkOutput($sformatf("v%0d_ack", i),      32'(obs_done), 1);
      checkOutput($sformatf("v%0d_src", i),      32'(obs_dc), 32'(vecs[i].dc));
      checkOutput($sformatf("v%0d_hit", i),      32'(obs_hit), 32'(vecs[i].hit));
      checkOutput($sformatf("v%0d_way", i),      32'(obs_way), 32'(vecs[i].way));
      checkOutput($sformatf("v%0d_wb", i),       32'(obs_wb), 32'(vecs[i].wb));
      checkOutput($sformatf("v%0d_wb_addr", i),  32'(obs_wb_addr), 32'(vecs[i].wb_addr));
      checkOutput($sformatf("v%0d_mem", i),      32'(obs_mem), 32'(!vecs[i].hit));
      checkOutput($sformatf("v%0d_mem_addr", i), 32'(obs_mem_addr), vecs[i].hit ? 32'd0 : 32'(vecs[i].addr));
      checkOutput($sformatf("v%0d_tag_wd", i),   32'(obs_tag), 32'(vecs[i].tag_wd));
      checkOutput($sformatf("v%0d_dirty_wd", i), 32'(obs_dirty), 32'(vecs[i].dirty_wd));
      checkOutput($sformatf("v%0d_we", i),       32'(obs_we), 32'(vecs[i].we));
      checkOutput($sformatf("v%0d_lat", i),      32'(obs_lat), 32'(vecs[i].lat));
    end
    plru = 3'b000;

    // Reset while a fill is outstanding: mem_req must drop with no ack.
    @(negedge clk);
    bus.ic_req = 1'b1; bus.ic_addr = 26'h0000277;
    saw_mem = 1'b0;
    for (int c = 0; c < 20 && !saw_mem; c++) begin
      @(negedge clk);
      saw_mem = bus.mem_req;
    end
    checkOutput("rstfill_mem_req_seen", 32'(saw_mem), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstfill_mem_req", 32'(bus.mem_req), 0);
    checkOutput("rstfill_ic_ack",  32'(bus.ic_ack), 0);
    checkOutput("rstfill_we",      32'(l2_block_we), 0);
    bus.ic_req = 1'b0;
    @(negedge clk);
    checkOutput("rstfill_hold_ack", 32'(bus.ic_ack), 0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 26'h0000277);
    checkOutput("post_rst_ack",    32'(obs_done), 1);
    checkOutput("post_rst_src",    32'(obs_dc), 0);
    checkOutput("post_rst_hit",    32'(obs_hit), 0);
    checkOutput("post_rst_we",     32'(obs_we), 32'b0001);
    checkOutput("post_rst_tag_wd", 32'(obs_tag), 32'h20001);
    checkOutput("post_rst_lat",    32'(obs_lat), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
